// File: rtl/mip_filter_engine.sv
`default_nettype none
// ============================================================================
// Module  : mip_filter_engine
// Brief   : Streams a grayscale image from ROM, applies a 3x3 dilation (max) or
//           erosion (min) and writes the result to RAM. Define
//           MIP_FILTER_BYPASS_EN to add a copy pass (both enables high).
// Rev     : 1.0  initial release
// ============================================================================
module mip_filter_engine #(
   parameter int IMG_W  = 320,
   parameter int IMG_H  = 240,
   parameter int PIX_W  = 8,
   parameter int ADDR_W = 17
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              dilation_en,
   input  logic              erosion_en,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [PIX_W-1:0]  rom_data,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [PIX_W-1:0]  ram_data,
   output logic              dilation_done,
   output logic              erosion_done,
   output logic              busy
);

   localparam int XW = $clog2(IMG_W);
   localparam int YW = $clog2(IMG_H + 2);
   localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
   localparam logic [XW-1:0]     c_X_MAX     = XW'(IMG_W - 1);
   localparam logic [YW-1:0]     c_Y_MAX     = YW'(IMG_H - 1);
   localparam logic [PIX_W-1:0]  c_PIX_MAX   = '1;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;
   typedef enum logic [1:0] {M_DIL = 2'd0, M_ERO = 2'd1, M_COPY = 2'd2} mode_t;

   state_t r_state, w_state_nxt;
   mode_t  r_mode, w_mode_sel;
   logic   w_start, w_keep, w_run, w_c_vld, w_use_ero;

   logic [ADDR_W-1:0] r_rom_addr, r_ram_addr, r_c_idx;
   logic [PIX_W-1:0]  r_ram_data, w_result;
   logic              r_ram_we, r_last_wr, r_in_act, r_c_fin;
   logic [XW-1:0]     r_kx, r_cx;
   logic [YW-1:0]     r_ky, r_cy;

   logic [PIX_W-1:0]  r_lb0 [IMG_W];
   logic [PIX_W-1:0]  r_lb1 [IMG_W];
   logic [PIX_W-1:0]  r_wl [3];
   logic [PIX_W-1:0]  r_wm [3];
   logic [PIX_W-1:0]  w_col_new [3];
   logic [PIX_W-1:0]  w_win [3][3];

   always_comb begin
      w_start    = 1'b0;
      w_mode_sel = M_DIL;
      w_keep     = 1'b0;
      if (dilation_en && !erosion_en) begin
         w_start    = 1'b1;
         w_mode_sel = M_DIL;
      end else if (!dilation_en && erosion_en) begin
         w_start    = 1'b1;
         w_mode_sel = M_ERO;
      end
`ifdef MIP_FILTER_BYPASS_EN
      else if (dilation_en && erosion_en) begin
         w_start    = 1'b1;
         w_mode_sel = M_COPY;
      end
`endif
      case (r_mode)
         M_DIL:   w_keep = dilation_en;
         M_ERO:   w_keep = erosion_en;
         default: w_keep = dilation_en && erosion_en;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_start) w_state_nxt = S_RUN;
         S_RUN: begin
            if (!w_keep)                   w_state_nxt = S_IDLE;
            else if (r_ram_we && r_last_wr) w_state_nxt = S_DONE;
         end
         S_DONE:  if (!w_keep) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_mode  <= M_DIL;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == S_IDLE && w_start) r_mode <= w_mode_sel;
      end
   end

   assign w_run = (r_state == S_RUN) && w_keep;
   // Centre index k-IMG_W-1 exists once incoming index k reaches IMG_W+1.
   assign w_c_vld = w_run && r_in_act && !r_c_fin &&
                    ((r_ky > YW'(1)) || ((r_ky == YW'(1)) && (r_kx != '0)));

   always_comb begin
      w_col_new[0] = r_lb1[r_kx];
      w_col_new[1] = r_lb0[r_kx];
      w_col_new[2] = rom_data;
      for (int r = 0; r < 3; r++) begin
         w_win[0][r] = r_wl[r];
         w_win[1][r] = r_wm[r];
         w_win[2][r] = w_col_new[r];
      end
      w_use_ero = (r_mode == M_ERO);
      w_result  = w_use_ero ? c_PIX_MAX : '0;
      // Masking by centre position keeps pad slots and stale buffer data out.
      for (int col = 0; col < 3; col++) begin
         for (int r = 0; r < 3; r++) begin
            if (!(col == 0 && r_cx == '0) && !(col == 2 && r_cx == c_X_MAX) &&
                !(r == 0 && r_cy == '0) && !(r == 2 && r_cy == c_Y_MAX)) begin
               if (w_use_ero) begin
                  if (w_win[col][r] < w_result) w_result = w_win[col][r];
               end else if (w_win[col][r] > w_result) begin
                  w_result = w_win[col][r];
               end
            end
         end
      end
`ifdef MIP_FILTER_BYPASS_EN
      if (r_mode == M_COPY) w_result = r_wm[1];
`endif
   end

   always_ff @(posedge clk) begin
      if (w_run && r_in_act) begin
         r_lb1[r_kx] <= r_lb0[r_kx];
         r_lb0[r_kx] <= rom_data;
         r_wl        <= r_wm;
         r_wm        <= w_col_new;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rom_addr <= '0;
         r_ram_addr <= '0;
         r_ram_data <= '0;
         r_ram_we   <= 1'b0;
         r_last_wr  <= 1'b0;
         r_in_act   <= 1'b0;
         r_c_fin    <= 1'b0;
         r_kx       <= '0;
         r_ky       <= '0;
         r_cx       <= '0;
         r_cy       <= '0;
         r_c_idx    <= '0;
      end else if (r_state == S_IDLE && w_start) begin
         r_rom_addr <= '0;
         r_ram_we   <= 1'b0;
         r_last_wr  <= 1'b0;
         r_in_act   <= 1'b0;
         r_c_fin    <= 1'b0;
         r_kx       <= '0;
         r_ky       <= '0;
         r_cx       <= '0;
         r_cy       <= '0;
         r_c_idx    <= '0;
      end else if (w_run) begin
         if (r_rom_addr != c_LAST_ADDR) r_rom_addr <= r_rom_addr + 1'b1;
         r_in_act <= 1'b1;
         if (r_in_act) begin
            if (r_kx == c_X_MAX) begin
               r_kx <= '0;
               r_ky <= r_ky + 1'b1;
            end else begin
               r_kx <= r_kx + 1'b1;
            end
         end
         r_ram_we <= w_c_vld;
         if (w_c_vld) begin
            r_ram_addr <= r_c_idx;
            r_ram_data <= w_result;
            r_last_wr  <= (r_c_idx == c_LAST_ADDR);
            r_c_idx    <= r_c_idx + 1'b1;
            if (r_c_idx == c_LAST_ADDR) r_c_fin <= 1'b1;
            if (r_cx == c_X_MAX) begin
               r_cx <= '0;
               r_cy <= r_cy + 1'b1;
            end else begin
               r_cx <= r_cx + 1'b1;
            end
         end
      end else begin
         r_ram_we  <= 1'b0;
         r_last_wr <= 1'b0;
      end
   end

   assign rom_addr      = r_rom_addr;
   assign ram_we        = r_ram_we;
   assign ram_addr      = r_ram_addr;
   assign ram_data      = r_ram_data;
   assign busy          = (r_state == S_RUN);
   assign dilation_done = (r_state == S_DONE) && (r_mode != M_ERO);
   assign erosion_done  = (r_state == S_DONE) && (r_mode != M_DIL);

endmodule
`default_nettype wire

// File: tb/tb_mip_filter_engine.sv
`default_nettype none
// ============================================================================
// Module  : tb_mip_filter_engine
// Brief   : Scoreboard bench for mip_filter_engine on a 4x3 image.
// Rev     : 1.0  initial release
// ============================================================================
module tb_mip_filter_engine;
   localparam int W  = 4;
   localparam int H  = 3;
   localparam int N  = W * H;
   localparam int AW = 17;

   logic          clk = 1'b0;
   logic          rst, dilation_en, erosion_en;
   logic [AW-1:0] rom_addr, ram_addr;
   logic [7:0]    rom_data, ram_data;
   logic          ram_we, dilation_done, erosion_done, busy;

   mip_filter_engine #(.IMG_W(W), .IMG_H(H), .PIX_W(8), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .dilation_en(dilation_en), .erosion_en(erosion_en),
      .rom_addr(rom_addr), .rom_data(rom_data), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_data(ram_data), .dilation_done(dilation_done), .erosion_done(erosion_done),
      .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int start = 0;
   int n_pass = 0;
   int n_total = 0;

   logic [7:0] rom_mem [N];
   logic [7:0] imgs [3][N];
   logic [7:0] exps [4][N];

   typedef struct {int t; int addr; int data;} exp_t;
   exp_t sb[$];
   exp_t m_e;

   always @(posedge clk) rom_data <= (rom_addr < N) ? rom_mem[rom_addr[3:0]] : 8'h00;

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Monitor: every write the DUT presents is matched against the scoreboard.
   always @(negedge clk) begin
      if (ram_we) begin
         if (sb.size() == 0) begin
            chk("unexpected_write_addr", int'(ram_addr), -1);
         end else begin
            m_e = sb.pop_front();
            chk("wr_addr", int'(ram_addr), m_e.addr);
            chk("wr_data", int'(ram_data), m_e.data);
            chk("wr_cycle", cyc - start, m_e.t);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_t(input int t);
      for (int i = 0; i < 500 && cyc < start + t; i++) tick();
   endtask

   task automatic push(input int e, input int n);
      for (int c = 0; c < n; c++) sb.push_back('{c + W + 3, c, int'(exps[e][c])});
   endtask

   task automatic start_pass(input bit dil, input int im, input int e, input int n);
      for (int i = 0; i < N; i++) rom_mem[i] = imgs[im][i];
      push(e, n);
      if (dil) dilation_en = 1'b1;
      else     erosion_en  = 1'b1;
      start = cyc + 1;
      wait_t(0);
      chk("busy_c0", int'(busy), 1);
      chk("rom_addr_c0", int'(rom_addr), 0);
      wait_t(5);
      chk("rom_addr_c5", int'(rom_addr), 5);
   endtask

   task automatic finish_pass(input bit dil);
      wait_t(18);
      chk("busy_c18", int'(busy), 1);
      chk("done_c18", int'(dilation_done | erosion_done), 0);
      wait_t(19);
      chk("busy_c19", int'(busy), 0);
      chk("dil_done_c19", int'(dilation_done), int'(dil));
      chk("ero_done_c19", int'(erosion_done), int'(!dil));
      chk("sb_empty", sb.size(), 0);
   endtask

   task automatic end_pass();
      dilation_en = 1'b0;
      erosion_en  = 1'b0;
      tick();
      chk("done_after_drop", int'(dilation_done | erosion_done), 0);
      chk("busy_after_drop", int'(busy), 0);
   endtask

   task automatic chk_reset_outputs();
      chk("rst_rom_addr", int'(rom_addr), 0);
      chk("rst_ram_addr", int'(ram_addr), 0);
      chk("rst_ram_data", int'(ram_data), 0);
      chk("rst_ram_we", int'(ram_we), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_dil_done", int'(dilation_done), 0);
      chk("rst_ero_done", int'(erosion_done), 0);
   endtask

   initial begin
      rst = 1'b1;
      dilation_en = 1'b0;
      erosion_en = 1'b0;
      imgs[0] = '{0, 0, 0, 0, 0, 255, 0, 0, 0, 0, 0, 0};
      imgs[1] = '{255, 255, 255, 255, 255, 255, 0, 255, 255, 255, 255, 255};
      for (int i = 0; i < N; i++) imgs[2][i] = 8'(10 * i);
      exps[0] = '{255, 255, 255, 0, 255, 255, 255, 0, 255, 255, 255, 0};
      exps[1] = '{255, 0, 0, 0, 255, 0, 0, 0, 255, 0, 0, 0};
      exps[2] = '{50, 60, 70, 70, 90, 100, 110, 110, 90, 100, 110, 110};
      exps[3] = '{0, 0, 10, 20, 0, 0, 10, 20, 40, 40, 50, 60};
      for (int i = 0; i < N; i++) rom_mem[i] = 8'h00;

      tick(); tick(); tick();
      chk_reset_outputs();
      rst = 1'b0;
      tick();

      // Both enables high: no pass may start.
      dilation_en = 1'b1;
      erosion_en  = 1'b1;
      for (int i = 0; i < 30; i++) begin
         tick();
         chk("both_busy", int'(busy), 0);
         chk("both_done", int'(dilation_done | erosion_done), 0);
         chk("both_rom_addr", int'(rom_addr), 0);
      end
      dilation_en = 1'b0;
      erosion_en  = 1'b0;
      tick();

      // Dilation of a single bright pixel, then DONE handshake hold.
      start_pass(1'b1, 0, 0, N);
      finish_pass(1'b1);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("done_hold", int'(dilation_done), 1);
      end
      end_pass();

      start_pass(1'b1, 2, 2, N);
      finish_pass(1'b1);
      end_pass();

      start_pass(1'b0, 1, 1, N);
      finish_pass(1'b0);
      end_pass();

      start_pass(1'b0, 2, 3, N);
      finish_pass(1'b0);
      end_pass();

      // Abort erosion at cycle 10: writes for centres 0..3 only.
      start_pass(1'b0, 2, 3, 4);
      wait_t(10);
      erosion_en = 1'b0;
      tick();
      chk("abort_we_c11", int'(ram_we), 0);
      chk("abort_busy_c11", int'(busy), 0);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("abort_no_done", int'(dilation_done | erosion_done), 0);
      end
      chk("abort_sb_empty", sb.size(), 0);

      start_pass(1'b0, 1, 1, N);
      finish_pass(1'b0);
      end_pass();

      // Reset in the middle of a dilation pass, enable kept high.
      start_pass(1'b1, 2, 2, N);
      wait_t(9);
      chk("we_before_rst", int'(ram_we), 1);
      rst = 1'b1;
      #1;
      chk_reset_outputs();
      tick();
      tick();
      sb.delete();
      push(2, N);
      rst = 1'b0;
      start = cyc + 1;
      wait_t(0);
      chk("rerun_busy_c0", int'(busy), 1);
      chk("rerun_rom_addr_c0", int'(rom_addr), 0);
      finish_pass(1'b1);
      end_pass();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mip_filter_engine.md
# mip_filter_engine

Responder side of the MIP control flags. Consumes `dilation_en` / `erosion_en` from the control FSM and streams a grayscale image from the source ROM in raster order. Applies a 3x3 morphological dilation (max) or erosion (min) and writes each result pixel to the frame RAM. Reports completion on `dilation_done` / `erosion_done`, which close the control FSM's FILTER stage.

## Interface
- `IMG_W`, 320, image width in pixels (≥ 3)
- `IMG_H`, 240, image height in lines (≥ 3)
- `PIX_W`, 8, pixel width in bits
- `ADDR_W`, 17, ROM/RAM address width; must satisfy 2^ADDR_W ≥ IMG_W*IMG_H
- `clk`  in  1  system clock; the block's only clock
- `rst`  in  1  reset, asynchronous, active-high
- `dilation_en`  in  1  request dilation pass; level, held for the whole pass
- `erosion_en`  in  1  request erosion pass; level, held for the whole pass
- `rom_addr`  out  ADDR_W  source pixel address
- `rom_data`  in  PIX_W  source pixel; valid 1 cycle after `rom_addr`
- `ram_we`  out  1  result write strobe
- `ram_addr`  out  ADDR_W  result address, y*IMG_W + x
- `ram_data`  out  PIX_W  result pixel
- `dilation_done`  out  1  dilation pass complete; level
- `erosion_done`  out  1  erosion pass complete; level
- `busy`  out  1  high in RUN

## Operation
- States: IDLE → RUN → DONE → IDLE.
- IDLE: exactly one enable high → latch mode (DIL or ERO), clear counters, enter RUN. Both high or neither high → stay in IDLE.
- RUN: issue `rom_addr` k = 0,1,… one per cycle up to IMG_W*IMG_H−1. After that, feed pad slots until the last output is written.
- Two line buffers (IMG_W × PIX_W each) plus a 3x3 window shift register.
- Output for center index c = y*IMG_W+x is computed once index c+IMG_W+1 (or a pad slot) has entered the window.
- Out-of-image neighbours take the neutral value: 0 for DIL, 2^PIX_W−1 for ERO.
  - Rows above y=0 and below y=IMG_H−1 are neutral.
  - Left neighbours are neutral at x=0; right neighbours are neutral at x=IMG_W−1. No wrap-around between lines.
- DIL: `ram_data` = max of 9 window values. ERO: `ram_data` = min of 9 window values. Unsigned compare.
- Exactly IMG_W*IMG_H writes per pass, addresses 0..IMG_W*IMG_H−1 ascending, one per cycle, no gaps.
- After the last write, enter DONE. In DONE, the done output matching the mode is high; the other stays low.
- DONE holds until the latched mode's enable drops, then returns to IDLE with done low the next cycle.
- Abort: the latched mode's enable drops during RUN → next cycle IDLE, `ram_we` low, no done asserted. Partial RAM contents are left as written.
- Enable changes during RUN other than dropping the latched one are ignored.
- Reset values: state IDLE; `rom_addr`, `ram_addr`, `ram_data` = 0; `ram_we`, `busy`, `dilation_done`, `erosion_done` = 0. Line buffer contents are don't-care; pad logic never exposes stale data.
- Reset mid-pass: all outputs return to reset values asynchronously. A new pass starts only via IDLE.

## Timing
- Cycle 0 = first RUN cycle; `rom_addr`=0 at cycle 0. `rom_data` for index k is sampled at cycle k+1.
- Write of center c: `ram_we`=1 with `ram_addr`=c at cycle c+IMG_W+3.
- First write at cycle IMG_W+3; last at IMG_W*IMG_H+IMG_W+2.
- Done rises at cycle IMG_W*IMG_H+IMG_W+3; `busy` falls the same cycle.
- Throughput 1 pixel/clk. No backpressure: RAM accepts every write.
- Latency from enable rising in IDLE to cycle 0: 1 clk.

## Configuration
- `MIP_FILTER_BYPASS_EN` defined:
  - Both enables high in IDLE starts a COPY pass: `ram_data` = center pixel, same addressing and timing as DIL/ERO.
  - In DONE, both done outputs are high.
  - Abort if either enable drops during RUN.
- Not defined: both enables high is ignored (stay IDLE). No copy datapath is built.

## Test plan
All scenarios use IMG_W=4, IMG_H=3, PIX_W=8.
- Dilation, all pixels 0 except (1,1)=255, `dilation_en` held → writes at cycles 7..18; addresses 0–2, 4–6, 8–10 = 255, addresses 3, 7, 11 = 0; `dilation_done`=1 at cycle 19; `erosion_done` stays 0.
- Erosion, all pixels 255 except (2,1)=0 → addresses 1–3, 5–7, 9–11 = 0, addresses 0, 4, 8 = 255; no wrap into x=0 of the next line.
- Handshake: in DONE, hold `dilation_en` 5 extra cycles → done stays high; drop it → done=0 and state IDLE the next cycle. Re-raise → new pass starting at `rom_addr` 0.
- Abort: drop `erosion_en` at cycle 10 → `ram_we`=0 from cycle 11, no done. Next `erosion_en` starts a clean pass with first write at address 0.
- Both enables high without macro → no ROM reads, no writes, done low for 30 cycles. With `MIP_FILTER_BYPASS_EN` → RAM equals ROM image, both done high at cycle 19.
- Assert `rst` at cycle 9 of a pass → all outputs 0 immediately. After release with enable still high → fresh pass with first write at cycle 7 relative to the new start.
